// File: rtl/i2c_pkg.sv
// Types and constants shared by the I2C initiator and target.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  localparam logic RW_READ = 1'b1;
  localparam logic ACK     = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } i2c_state_e;

  // Address 7'h00 is the general-call address, which this target never answers.
  function automatic logic addr_match(input logic [I2C_ADDR_W-1:0] rx_addr,
                                      input logic [I2C_ADDR_W-1:0] own_addr);
    return (rx_addr == own_addr) && (rx_addr != '0);
  endfunction

endpackage

// File: rtl/i2c_if.sv
// Open-drain I2C bus pins as seen by a target: sampled SCL/SDA in, SDA pull-low enable out.
interface i2c_if;
  import i2c_pkg::*;

  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport slave  (input scl_in, input sda_in, output sda_oe);
  modport master (output scl_in, output sda_in, input sda_oe);

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into clk_in and produces registered edge and START/STOP pulses.
// SYNC_STAGES must be at least 2.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_smp
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_hist;
  logic                   sda_hist;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Synchroniser chains, history flops and registered event pulses; lines reset to the idle-high level.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_hist  <= 1'b1;
      sda_hist  <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_smp   <= 1'b1;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_hist  <= scl_s;
      sda_hist  <= sda_s;
      scl_rise  <= ~scl_hist & scl_s;
      scl_fall  <= scl_hist & ~scl_s;
      // SDA must move while SCL is stably high on both samples to count as START/STOP.
      start_det <= scl_hist & scl_s & sda_hist & ~sda_s;
      stop_det  <= scl_hist & scl_s & ~sda_hist & sda_s;
      sda_smp   <= sda_s;
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: address match, write reception and read transmission, no clock stretching.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus ignored until START
// ADDR     | shifting in 7 address bits plus R/W
// ADDR_ACK | pulling SDA low for the address ack clock
// WR_DATA  | shifting in a write byte
// WR_ACK   | pulling SDA low for the write-byte ack clock
// RD_DATA  | driving the 8 bits of a read byte
// RD_ACK   | SDA released, sampling the initiator's ACK/NACK
module i2c_target
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  i2c_if.slave                  bus,
  input  logic [I2C_ADDR_W-1:0] own_addr_in,
  input  logic [I2C_BYTE_W-1:0] tx_data_in,
  output logic                  tx_load_out,
  output logic [I2C_BYTE_W-1:0] rx_data_out,
  output logic                  rx_valid_out,
  output logic                  busy_out
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_smp;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .scl_in   (bus.scl_in),
    .sda_in   (bus.sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_smp  (sda_smp)
  );

  i2c_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic                  got_byte_q, got_byte_d;
  logic                  rw_q, rw_d;
  logic                  ack_q, ack_d;
  logic                  sda_oe_q, sda_oe_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_load_q, tx_load_d;

  // State and datapath registers.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      got_byte_q <= 1'b0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      got_byte_q <= got_byte_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
    end
  end

  // Next state: START/STOP win over everything, otherwise advance on SCL falls.
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR:     if (scl_fall && got_byte_q)
                    state_d = addr_match(shift_q[7:1], own_addr_in) ? ADDR_ACK : IDLE;
        ADDR_ACK: if (scl_fall) state_d = (rw_q == RW_READ) ? RD_DATA : WR_DATA;
        WR_DATA:  if (scl_fall && got_byte_q) state_d = WR_ACK;
        WR_ACK:   if (scl_fall) state_d = WR_DATA;
        RD_DATA:  if (scl_fall && (bit_cnt_q == 3'd7)) state_d = RD_ACK;
        RD_ACK:   if (scl_fall) state_d = (ack_q == ACK) ? RD_DATA : IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  // Datapath and output updates: sample on SCL rise, change SDA only on SCL fall.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    got_byte_d = got_byte_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    if (start_det || stop_det) begin
      bit_cnt_d  = '0;
      got_byte_d = 1'b0;
      sda_oe_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR, WR_DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_smp};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) got_byte_d = 1'b1;
          end else if (scl_fall && got_byte_q) begin
            got_byte_d = 1'b0;
            if (state_q == ADDR) begin
              if (addr_match(shift_q[7:1], own_addr_in)) begin
                sda_oe_d = 1'b1;
                rw_d     = shift_q[0];
              end
            end else begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q == RW_READ) begin
              shift_d   = tx_data_in;
              tx_load_d = 1'b1;
              sda_oe_d  = ~tx_data_in[7];
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ack_d = sda_smp;
          end else if (scl_fall) begin
            bit_cnt_d = '0;
            if (ack_q == ACK) begin
              shift_d   = tx_data_in;
              tx_load_d = 1'b1;
              sda_oe_d  = ~tx_data_in[7];
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign rx_data_out  = rx_data_q;
  assign rx_valid_out = rx_valid_q;
  assign tx_load_out  = tx_load_q;
  assign busy_out     = (state_q != IDLE);

endmodule
